head_ptr_lookup: RTL
====================

Name: head_ptr_lookup

Overview:
Front stage of the hash-table search path, directly upstream of the data-table search stage.
- Accepts a command, hashes its key to a bucket and reads the bucket's head pointer from an internal head table.
- Emits an ht_pdata_t task with cmd, bucket, head_ptr and head_ptr_val filled in.
- Owns head-table initialisation (clear) and applies head-pointer updates from the insert/delete engine.

Parameters:
KEY_WIDTH, KEY_WIDTH (package), key width in bits
BUCKET_WIDTH, 8, head table has 2^BUCKET_WIDTH entries
A_WIDTH, TABLE_ADDR_WIDTH, head pointer width

Ports:
clk_i  in  1  clock
rst_n_i  in  1  reset, asynchronous assert, active-low
cmd_i  in  ht_command_t  command (key, value, opcode)
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command accepted when valid&&ready
pdata_o  out  ht_pdata_t  task to search stage
pdata_valid_o  out  1  task valid
pdata_ready_i  in  1  search stage ready
head_upd_en_i  in  1  head-table write strobe
head_upd_bucket_i  in  BUCKET_WIDTH  bucket to write
head_upd_ptr_i  in  A_WIDTH  new head pointer
head_upd_ptr_val_i  in  1  new head pointer valid
clear_req_i  in  1  request full re-clear (level, sampled in RUN_S)
init_done_o  out  1  high in RUN_S only

Behaviour:
- Reset: state=CLEAR_S, clear counter=0, occupancy=0, FIFO empty. Outputs: cmd_ready_o=0, pdata_valid_o=0, pdata_o='0, init_done_o=0.
- Hash: bucket = XOR of KEY_WIDTH split into BUCKET_WIDTH chunks, LSB-aligned, top chunk zero-padded. Purely combinational on cmd_i.key.
- Head table: 2^BUCKET_WIDTH x {ptr_val, ptr}, one write and one read port.
  - Read is registered; data is available the cycle after the read is issued.
  - Read-during-write to the same address returns old data in the RAM; the bypass below corrects it.
- States:
  - CLEAR_S: writes {0,0} to bucket = counter, counter+1 per cycle. After the last bucket (2^BUCKET_WIDTH cycles), goes to RUN_S; init_done_o=1 from the next cycle. head_upd_en_i is ignored in this state.
  - RUN_S: lookups and updates. clear_req_i=1 forces cmd_ready_o=0 and moves to DRAIN_S.
  - DRAIN_S: cmd_ready_o=0, updates still applied. When occupancy==0, goes to CLEAR_S with counter=0; init_done_o=0.
- Lookup pipeline:
  - Accept cycle T issues the read and latches cmd and bucket.
  - Cycle T+1: RAM data plus the in-flight cmd/bucket are pushed into a 2-entry FIFO; the FIFO head drives pdata_o/pdata_valid_o.
  - Minimum latency: accept at T, pdata_valid_o=1 at T+2.
- Occupancy counter (0..2) counts accepted tasks not yet popped: +1 on accept, -1 on pop.
  - cmd_ready_o = RUN_S && !clear_req_i && (occ<2 || (pdata_valid_o && pdata_ready_i)).
  - Full throughput of 1/cycle with pdata_ready_i held high.
  - The FIFO never overflows.
- Update bypass: an update to bucket B overrides the captured {ptr_val, ptr} of the in-flight read of B when it occurs in either:
  - the read-issue cycle, or
  - the data-return cycle.
  If both cycles carry updates to B, the later one wins. Entries already in the FIFO are not patched; ordering is the insert/delete engine's responsibility.
- pdata_o fields: cmd=accepted command, bucket=hash, head_ptr/head_ptr_val from the table (after bypass).
- pdata_o and pdata_valid_o are stable while valid && !ready.
- Reset mid-operation: everything returns to reset values, in-flight tasks are discarded, and the full clear restarts.

Decomposition:
- hash_table package additions:
  - BUCKET_WIDTH constant.
  - head_ram_data_t {ptr_val, ptr}.
  - bucket field in ht_pdata_t.
  - Hash fold function, shared with the insert/delete engine.
- Sub-module: ht_pdata_fifo2 (2-entry FIFO, valid/ready on both sides, async active-low reset).
- The head table is inferred inline.

Test Plan:
- Reset release: cmd_valid_i=1 throughout -> cmd_ready_o=0 for 256 cycles; init_done_o rises, first accept on the following cycle; every bucket reads ptr_val=0.
- Update head_upd bucket 0x08 ptr=0x1A val=1, then one cycle later key 0x12345678 (bucket 0x08) -> pdata_o.bucket=0x08, head_ptr=0x1A, head_ptr_val=1, valid 2 cycles after accept.
- Update bucket 0x08 ptr=0x2B in the same cycle as the lookup of key 0x12345678 -> head_ptr=0x2B; repeat with the update on the next cycle -> also 0x2B.
- Back-to-back keys 0x01, 0x02, 0x03 with pdata_ready_i=0 -> two accepted, cmd_ready_o=0 on the third; the third is accepted in the same cycle ready rises; output order 0x01, 0x02, 0x03 and pdata_o held stable while stalled.
- clear_req_i pulse with 2 tasks pending -> DRAIN_S until both popped, then 256-cycle clear; bucket 0x08 then returns head_ptr_val=0.
- rst_n_i asserted with a task in flight -> pdata_valid_o=0 immediately, no stale task after the re-clear.

Source files
------------

// File: rtl/head_ptr_lookup_pkg.sv
// Shared types and constants for the hash-table search path: command and task
// structs, head-table entry layout, and the key-to-bucket fold.
package head_ptr_lookup_pkg;

  localparam int KEY_WIDTH        = 32;
  localparam int VALUE_WIDTH      = 16;
  localparam int TABLE_ADDR_WIDTH = 8;
  localparam int A_WIDTH          = TABLE_ADDR_WIDTH;
  localparam int BUCKET_WIDTH     = 8;
  localparam int NUM_BUCKETS      = 1 << BUCKET_WIDTH;
  localparam int HASH_CHUNKS      = (KEY_WIDTH + BUCKET_WIDTH - 1) / BUCKET_WIDTH;

  typedef enum logic [1:0] {
    OP_SEARCH = 2'd0,
    OP_INSERT = 2'd1,
    OP_DELETE = 2'd2
  } ht_opcode_t;

  typedef struct packed {
    logic [KEY_WIDTH-1:0]   key;
    logic [VALUE_WIDTH-1:0] value;
    ht_opcode_t             opcode;
  } ht_command_t;

  typedef struct packed {
    logic               ptr_val;
    logic [A_WIDTH-1:0] ptr;
  } head_ram_data_t;

  typedef struct packed {
    ht_command_t             cmd;
    logic [BUCKET_WIDTH-1:0] bucket;
    logic [A_WIDTH-1:0]      head_ptr;
    logic                    head_ptr_val;
  } ht_pdata_t;

  // Control FSM state, also visible on the debug port of the lookup stage.
  typedef enum logic [1:0] {
    CLEAR_S = 2'd0,
    RUN_S   = 2'd1,
    DRAIN_S = 2'd2
  } hpl_state_t;

  // XOR-fold of the key in BUCKET_WIDTH chunks, LSB-aligned; the top chunk
  // is zero-padded when KEY_WIDTH is not a multiple of BUCKET_WIDTH.
  function automatic logic [BUCKET_WIDTH-1:0] hash_fold(input logic [KEY_WIDTH-1:0] key);
    logic [HASH_CHUNKS*BUCKET_WIDTH-1:0] padded;
    logic [BUCKET_WIDTH-1:0]             acc;
    padded                = '0;
    padded[KEY_WIDTH-1:0] = key;
    acc                   = '0;
    for (int i = 0; i < HASH_CHUNKS; i++) begin
      acc = acc ^ padded[i*BUCKET_WIDTH +: BUCKET_WIDTH];
    end
    return acc;
  endfunction

endpackage

// File: rtl/ht_pdata_fifo2.sv
// Two-entry task FIFO between the head-table read and the search stage.
// Handshake: a transfer happens on a side in any cycle where valid && ready;
// the sender holds data and valid stable until that cycle.
module ht_pdata_fifo2
  import head_ptr_lookup_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_n_i,
  input  ht_pdata_t in_data,
  input  logic      in_valid,
  output logic      in_ready,
  output ht_pdata_t out_data,
  output logic      out_valid,
  input  logic      out_ready
);

  ht_pdata_t  mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic       push;
  logic       pop;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = mem_q[rd_ptr_q];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Storage, pointers and fill count; everything clears on reset so the
  // output reads as all-zero straight out of reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/head_ptr_lookup.sv
// Front stage of the hash search path: hashes the command key, reads the
// bucket head pointer from the head table and hands a task to the search
// stage. Also owns head-table clearing and applies head-pointer updates.
// Handshakes: cmd and pdata transfer on valid && ready; pdata is held stable
// while valid && !ready.
module head_ptr_lookup
  import head_ptr_lookup_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  ht_command_t             cmd_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  output ht_pdata_t               pdata_o,
  output logic                    pdata_valid_o,
  input  logic                    pdata_ready_i,
  input  logic                    head_upd_en_i,
  input  logic [BUCKET_WIDTH-1:0] head_upd_bucket_i,
  input  logic [A_WIDTH-1:0]      head_upd_ptr_i,
  input  logic                    head_upd_ptr_val_i,
  input  logic                    clear_req_i,
  output logic                    init_done_o,
  output hpl_state_t              state_o
);

  hpl_state_t              state_q, state_d;
  logic [BUCKET_WIDTH-1:0] clr_cnt_q;
  logic                    clr_last;
  logic                    clearing;
  logic [1:0]              occ_q;
  logic                    accept;
  logic                    pop;
  logic [BUCKET_WIDTH-1:0] cmd_bucket;

  logic                    upd_live;
  head_ram_data_t          upd_data;
  logic                    ram_we;
  logic [BUCKET_WIDTH-1:0] ram_waddr;
  head_ram_data_t          ram_wdata;
  head_ram_data_t          head_mem [NUM_BUCKETS];
  head_ram_data_t          rd_data_q;

  logic                    s1_valid_q;
  ht_command_t             s1_cmd_q;
  logic [BUCKET_WIDTH-1:0] s1_bucket_q;
  logic                    s1_byp_q;
  head_ram_data_t          s1_byp_data_q;
  head_ram_data_t          push_head;
  ht_pdata_t               push_data;
  logic                    fifo_in_ready;

  assign cmd_bucket = hash_fold(cmd_i.key);
  assign accept     = cmd_valid_i && cmd_ready_o;
  assign pop        = pdata_valid_o && pdata_ready_i;
  assign clr_last   = (clr_cnt_q == BUCKET_WIDTH'(NUM_BUCKETS - 1));
  assign state_o    = state_q;

  // Updates from the insert/delete engine are dropped while clearing.
  assign upd_live = head_upd_en_i && !clearing;
  assign upd_data = '{ptr_val: head_upd_ptr_val_i, ptr: head_upd_ptr_i};

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= CLEAR_S;
    else          state_q <= state_d;
  end

  // FSM next state: clear all buckets, run, and drain pending tasks before re-clearing.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CLEAR_S: if (clr_last)      state_d = RUN_S;
      RUN_S:   if (clear_req_i)   state_d = DRAIN_S;
      DRAIN_S: if (occ_q == 2'd0) state_d = CLEAR_S;
      default:                    state_d = CLEAR_S;
    endcase
  end

  // FSM outputs; ready also admits a new task when one leaves in the same cycle.
  always_comb begin
    cmd_ready_o = 1'b0;
    init_done_o = 1'b0;
    clearing    = 1'b0;
    unique case (state_q)
      CLEAR_S: clearing = 1'b1;
      RUN_S: begin
        init_done_o = 1'b1;
        cmd_ready_o = !clear_req_i && ((occ_q < 2'd2) || pop);
      end
      default: ;
    endcase
  end

  // Clear sweep counter; sits at zero outside CLEAR_S so each clear starts at bucket 0.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)      clr_cnt_q <= '0;
    else if (clearing) clr_cnt_q <= clr_cnt_q + 1'b1;
    else               clr_cnt_q <= '0;
  end

  // Tasks accepted but not yet taken by the search stage (in flight or queued).
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      occ_q <= 2'd0;
    end else begin
      unique case ({accept, pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign ram_we    = clearing || upd_live;
  assign ram_waddr = clearing ? clr_cnt_q : head_upd_bucket_i;
  assign ram_wdata = clearing ? head_ram_data_t'('0) : upd_data;

  // Head table: one write port, one registered read port (old data on a same-address collision).
  always_ff @(posedge clk_i) begin
    if (ram_we) head_mem[ram_waddr] <= ram_wdata;
    if (accept) rd_data_q <= head_mem[cmd_bucket];
  end

  // In-flight read: command, bucket and any update to that bucket seen in the issue cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_valid_q    <= 1'b0;
      s1_cmd_q      <= '0;
      s1_bucket_q   <= '0;
      s1_byp_q      <= 1'b0;
      s1_byp_data_q <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_cmd_q      <= cmd_i;
        s1_bucket_q   <= cmd_bucket;
        s1_byp_q      <= upd_live && (head_upd_bucket_i == cmd_bucket);
        s1_byp_data_q <= upd_data;
      end
    end
  end

  // Returned head entry with bypass; a data-return-cycle update beats an issue-cycle one.
  always_comb begin
    push_head = rd_data_q;
    if (s1_byp_q) push_head = s1_byp_data_q;
    if (upd_live && (head_upd_bucket_i == s1_bucket_q)) push_head = upd_data;
    push_data              = '0;
    push_data.cmd          = s1_cmd_q;
    push_data.bucket       = s1_bucket_q;
    push_data.head_ptr     = push_head.ptr;
    push_data.head_ptr_val = push_head.ptr_val;
  end

  ht_pdata_fifo2 u_fifo (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .in_data   (push_data),
    .in_valid  (s1_valid_q),
    .in_ready  (fifo_in_ready),
    .out_data  (pdata_o),
    .out_valid (pdata_valid_o),
    .out_ready (pdata_ready_i)
  );

  // The occupancy limit on accepts means the FIFO always has room for a returning read.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_n_i)
                                  s1_valid_q |-> fifo_in_ready);

endmodule
